// File: rtl/phase_a_sequencer_pkg.sv
// Shared definitions for the phase_a round sequencer.
// Holds the default geometry (accumulator width, digit radix, round count,
// watchdog limit), the spliced-digit width and the sequencer state encoding.
package phase_a_sequencer_pkg;

  localparam int SIZE_DEF    = 3072;
  localparam int RADIX_DEF   = 78;
  localparam int ROUNDS_DEF  = 40;
  localparam int TIMEOUT_DEF = 64;

  // Each digit spliced above the accumulator carries one extra bit.
  localparam int DIGIT_W = RADIX_DEF + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FIRE,
    ST_WAIT,
    ST_CAPTURE,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/phase_a_sequencer_if.sv
// Bus between the sequencer and one phase_a reduction round.
//   pa_a      : operand word {digit, acc} presented to phase_a
//   pa_en     : one-cycle round fire pulse
//   pa_new_a  : reduced accumulator returned by phase_a
//   pa_en_out : round-complete strobe from phase_a
// master = sequencer side, slave = phase_a side.
interface phase_a_sequencer_if
  import phase_a_sequencer_pkg::*;
#(
  parameter int SIZE  = SIZE_DEF,
  parameter int RADIX = RADIX_DEF
);

  logic [SIZE+RADIX:0] pa_a;
  logic                pa_en;
  logic [SIZE-1:0]     pa_new_a;
  logic                pa_en_out;

  modport master (
    output pa_a,
    output pa_en,
    input  pa_new_a,
    input  pa_en_out
  );

  modport slave (
    input  pa_a,
    input  pa_en,
    output pa_new_a,
    output pa_en_out
  );

endinterface

// File: rtl/pa_watchdog.sv
// Loadable cycle counter guarding one phase_a round.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : reload the count to zero (has priority)
//   enable     : count one cycle
//   expired    : count has reached TIMEOUT-1
module pa_watchdog
  import phase_a_sequencer_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expired) begin
      // Saturate at the limit so the flag stays up until cleared.
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == CW'(TIMEOUT - 1));

endmodule

// File: rtl/phase_a_sequencer.sv
// Digit-serial initiator for the phase_a reduction round.
// Latches a wide operand, then for each of ROUNDS rounds presents
// {digit k, acc} to phase_a, fires a one-cycle pa_en and captures pa_new_a
// into acc on pa_en_out. Reports the final acc with a done/error handshake;
// a round that never completes within TIMEOUT cycles aborts with error.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   t_in       : {digits[ROUNDS-1:0], initial acc}, sampled on accepted start
//   pa         : phase_a bus (master side)
//   result     : final (or partial, on error) accumulator
//   busy       : operation in progress, from accepted start until done
//   done       : one-cycle completion pulse
//   error      : timeout flag, valid with done, held until the next start
module phase_a_sequencer
  import phase_a_sequencer_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int RADIX   = RADIX_DEF,
  parameter int ROUNDS  = ROUNDS_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [SIZE+ROUNDS*(RADIX+1)-1:0]  t_in,
  phase_a_sequencer_if.master               pa,
  output logic [SIZE-1:0]                   result,
  output logic                              busy,
  output logic                              done,
  output logic                              error
);

  localparam int DW = RADIX + 1;
  localparam int OW = ROUNDS * DW;
  localparam int KW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;

  state_t          state_reg;
  logic [OW-1:0]   opnd_reg;   // remaining digits, current digit in the low DW bits
  logic [SIZE-1:0] acc_reg;
  logic [KW-1:0]   k_reg;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  assign wd_clear  = (state_reg == ST_FIRE);
  assign wd_enable = (state_reg == ST_WAIT);

  pa_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      opnd_reg  <= '0;
      acc_reg   <= '0;
      k_reg     <= '0;
      pa.pa_a   <= '0;
      pa.pa_en  <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            opnd_reg  <= t_in[SIZE +: OW];
            acc_reg   <= t_in[SIZE-1:0];
            k_reg     <= '0;
            error     <= 1'b0;
            busy      <= 1'b1;
            state_reg <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          pa.pa_a   <= {opnd_reg[DW-1:0], acc_reg};
          pa.pa_en  <= 1'b1;
          state_reg <= ST_FIRE;
        end

        ST_FIRE: begin
          // pa_a stays untouched until the next CAPTURE: phase_a samples it
          // some cycles after the en edge.
          pa.pa_en  <= 1'b0;
          state_reg <= ST_WAIT;
        end

        ST_WAIT: begin
          // A completion in the expiry cycle still counts as success.
          if (pa.pa_en_out) begin
            acc_reg   <= pa.pa_new_a;
            state_reg <= ST_CAPTURE;
          end else if (wd_expired) begin
            result    <= acc_reg;
            error     <= 1'b1;
            done      <= 1'b1;
            state_reg <= ST_ERR;
          end
        end

        ST_CAPTURE: begin
          // Passing through here keeps pa_en low for a cycle between
          // pulses, which phase_a's rising-edge detector relies on.
          if (k_reg == KW'(ROUNDS - 1)) begin
            result    <= acc_reg;
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else begin
            k_reg     <= k_reg + 1'b1;
            opnd_reg  <= opnd_reg >> DW;
            pa.pa_a   <= {opnd_reg[DW +: DW], acc_reg};
            pa.pa_en  <= 1'b1;
            state_reg <= ST_FIRE;
          end
        end

        ST_DONE, ST_ERR: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_a_sequencer.sv
// Bench for phase_a_sequencer: behavioural phase_a responder, a per-cycle
// compare process driven by a sum-of-digits reference, and directed runs.
module tb_phase_a_sequencer;
  import phase_a_sequencer_pkg::*;

  localparam int SIZE    = SIZE_DEF;
  localparam int RADIX   = RADIX_DEF;
  localparam int ROUNDS  = ROUNDS_DEF;
  localparam int TIMEOUT = TIMEOUT_DEF;
  localparam int DW      = RADIX + 1;
  localparam int TW      = SIZE + ROUNDS * DW;
  localparam int AW      = SIZE + DW;
  localparam int MAXCYC  = 5000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [TW-1:0]   t_in;
  logic [SIZE-1:0] result;
  logic            busy;
  logic            done;
  logic            error;

  phase_a_sequencer_if #(.SIZE(SIZE), .RADIX(RADIX)) pa_if ();

  phase_a_sequencer #(
    .SIZE    (SIZE),
    .RADIX   (RADIX),
    .ROUNDS  (ROUNDS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .t_in   (t_in),
    .pa     (pa_if),
    .result (result),
    .busy   (busy),
    .done   (done),
    .error  (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared bench state
  int            n_checks = 0;
  int            n_pass   = 0;
  int            lpa      = 17;   // phase_a en -> en_out latency
  int            stall_round = -1; // model never answers this round
  int            abort_round = -1; // round at which an error is expected
  bit            spurious = 1'b0;
  int            model_rounds = 0;
  logic [TW-1:0] exp_t = '0;
  int            pulse_cnt = 0;
  int            done_cnt  = 0;
  int            done_cyc  = 0;
  int            cyc_g     = 0;
  int            pen_cyc [ROUNDS];

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%h, required 0x%h (low 64 bits)", name, got[63:0], exp[63:0]);
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, got, exp);
  endtask

  function automatic logic [DW-1:0] digit_of(input logic [TW-1:0] t, input int k);
    return t[SIZE + k*DW +: DW];
  endfunction

  // Reference: every round adds its digit to the accumulator modulo 2^SIZE.
  function automatic logic [SIZE-1:0] acc_after(input logic [TW-1:0] t, input int n);
    logic [SIZE-1:0] a;
    a = t[SIZE-1:0];
    for (int i = 0; i < n; i++) a = a + SIZE'(digit_of(t, i));
    return a;
  endfunction

  function automatic logic [TW-1:0] rand_t();
    logic [TW-1:0] t;
    t = '0;
    for (int i = 0; i < TW/32 + 1; i++) t = {t[TW-33:0], 32'($urandom())};
    return t;
  endfunction

  function automatic logic [TW-1:0] ones_t();
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < ROUNDS; k++) t[SIZE + k*DW +: DW] = DW'(1);
    return t;
  endfunction

  // Behavioural phase_a: on a rising en, answer lpa cycles later with
  // new_a = a[SIZE-1:0] + a[SIZE+RADIX:SIZE]. Optional stall and
  // spurious strobes (during FIRE and CAPTURE) carrying an all-ones word.
  initial begin
    int            cd;
    bit            prev_en;
    bit            answered;
    logic [AW-1:0] lat_a;
    cd = 0; prev_en = 1'b0; answered = 1'b0; lat_a = '0;
    pa_if.pa_en_out = 1'b0;
    pa_if.pa_new_a  = '0;
    forever begin
      @(posedge clk); #1;
      pa_if.pa_en_out = 1'b0;
      if (!rst_n) begin
        cd = 0; prev_en = 1'b0; answered = 1'b0;
      end else begin
        if (answered && spurious) begin
          pa_if.pa_en_out = 1'b1;
          pa_if.pa_new_a  = '1;
        end
        answered = 1'b0;
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            pa_if.pa_en_out = 1'b1;
            pa_if.pa_new_a  = lat_a[SIZE-1:0] + SIZE'(lat_a[AW-1:SIZE]);
            answered = 1'b1;
          end
        end
        if (pa_if.pa_en && !prev_en) begin
          if (model_rounds != stall_round) begin
            cd = lpa;
            lat_a = pa_if.pa_a;
          end
          model_rounds++;
          if (spurious) begin
            pa_if.pa_en_out = 1'b1;
            pa_if.pa_new_a  = '1;
          end
        end
        prev_en = pa_if.pa_en;
      end
    end
  end

  // Per-cycle compare: every pa_en pulse must follow a low cycle and carry
  // {digit k, reference acc after k rounds}; every done must carry the
  // reference result and the expected error flag.
  initial begin
    bit prev_en;
    prev_en = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc_g++;
      if (!rst_n) begin
        prev_en = 1'b0;
      end else begin
        if (pa_if.pa_en) begin
          chk("pa_en_low_before_pulse", AW'(prev_en), AW'(0));
          if (pulse_cnt < ROUNDS) begin
            pen_cyc[pulse_cnt] = cyc_g;
            chk("pa_a_word", pa_if.pa_a,
                {digit_of(exp_t, pulse_cnt), acc_after(exp_t, pulse_cnt)});
          end
          pulse_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc_g;
          chk("error_with_done", AW'(error), AW'(abort_round >= 0));
          chk("result_vs_model", AW'(result),
              AW'(acc_after(exp_t, (abort_round >= 0) ? abort_round : ROUNDS)));
        end
        prev_en = pa_if.pa_en;
      end
    end
  end

  task automatic run_op(input logic [TW-1:0] t, input bit hold, input int lpa_v,
                        input int stall_v, input int abort_v, input bit spur,
                        output int lat);
    bit to;
    lpa = lpa_v; stall_round = stall_v; abort_round = abort_v; spurious = spur;
    exp_t = t; pulse_cnt = 0; done_cnt = 0; model_rounds = 0;
    @(posedge clk); #1;
    t_in = t; start = 1'b1;
    lat = 0; to = 1'b1;
    for (int c = 0; c < MAXCYC; c++) begin
      @(posedge clk); #1;
      lat++;
      if (c == 0) begin
        chk("busy_after_start", AW'(busy), AW'(1));
        chk("error_cleared_by_start", AW'(error), AW'(0));
      end
      if (!hold) start = 1'b0;
      if (done) begin
        to = 1'b0;
        start = 1'b0;
        break;
      end
    end
    n_checks++;
    if (!to) n_pass++;
    else $display("FAIL done_wait: no done within %0d cycles", MAXCYC);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_int("done_pulse_count", done_cnt, 1);
    chk_int("pa_en_pulse_count", pulse_cnt, (abort_v >= 0) ? abort_v + 1 : ROUNDS);
    chk("busy_after_done", AW'(busy), AW'(0));
    chk("done_is_pulse", AW'(done), AW'(0));
    $display("op: lpa=%0d hold=%0d stall=%0d spur=%0d latency=%0d pulses=%0d error=%0d result_lo=0x%h",
             lpa_v, hold, stall_v, spur, lat, pulse_cnt, error, result[63:0]);
  endtask

  initial begin
    int            lat;
    logic [TW-1:0] t_ones;
    logic [TW-1:0] t_rand;
    logic [SIZE-1:0] clean_result;
    bit            reached;

    rst_n = 1'b0; start = 1'b0; t_in = '0;
    t_ones = ones_t();
    t_rand = rand_t();

    repeat (2) @(posedge clk);
    #1;
    chk("reset_pa_a", pa_if.pa_a, AW'(0));
    chk("reset_pa_en", AW'(pa_if.pa_en), AW'(0));
    chk("reset_result", AW'(result), AW'(0));
    chk("reset_busy", AW'(busy), AW'(0));
    chk("reset_done", AW'(done), AW'(0));
    chk("reset_error", AW'(error), AW'(0));
    rst_n = 1'b1;

    // Every digit is 1, so each round adds 1: result 40 after 2+40*19 cycles.
    run_op(t_ones, 1'b0, 17, -1, -1, 1'b0, lat);
    chk("ones_result_literal", AW'(result), AW'(40));
    chk_int("ones_latency", lat, 762);

    // Random operand against the reference loop.
    run_op(t_rand, 1'b0, 17, -1, -1, 1'b0, lat);
    clean_result = result;
    chk_int("rand_latency", lat, 2 + ROUNDS * (17 + 2));

    // Stall on round 5: 64 WAIT cycles after the FIRE cycle of the 6th
    // pulse, so done lands TIMEOUT+1 edges after pa_en is first seen high.
    run_op(t_ones, 1'b0, 17, 5, 5, 1'b0, lat);
    chk("stall_error_literal", AW'(error), AW'(1));
    chk("stall_result_literal", AW'(result), AW'(5));
    chk_int("stall_timeout_delay", done_cyc - pen_cyc[5], TIMEOUT + 1);

    // start held high throughout: one operation only (also clears error).
    run_op(t_rand, 1'b1, 17, -1, -1, 1'b0, lat);
    chk("held_start_result", AW'(result), AW'(clean_result));

    // Spurious strobes during FIRE and CAPTURE must not disturb acc.
    run_op(t_rand, 1'b0, 17, -1, -1, 1'b1, lat);
    chk("spurious_vs_clean", AW'(result), AW'(clean_result));

    // en_out in the very cycle the watchdog expires: capture wins.
    run_op(t_rand, 1'b0, TIMEOUT, -1, -1, 1'b0, lat);
    chk("edge_lpa_result", AW'(result), AW'(clean_result));
    chk_int("edge_lpa_latency", lat, 2 + ROUNDS * (TIMEOUT + 2));

    // One cycle too slow: abort on the first round with the initial acc.
    run_op(t_rand, 1'b0, TIMEOUT + 1, -1, 0, 1'b0, lat);
    chk("late_result_initial_acc", AW'(result), AW'(t_rand[SIZE-1:0]));

    // Reset during round 20.
    lpa = 17; stall_round = -1; abort_round = -1; spurious = 1'b0;
    exp_t = t_rand; pulse_cnt = 0; done_cnt = 0; model_rounds = 0;
    @(posedge clk); #1;
    t_in = t_rand; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < MAXCYC; c++) begin
      if (pulse_cnt >= 21) begin reached = 1'b1; break; end
      @(posedge clk); #1;
    end
    n_checks++;
    if (reached) n_pass++;
    else $display("FAIL round20_wait: pulse count %0d never reached 21", pulse_cnt);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_pa_a", pa_if.pa_a, AW'(0));
    chk("midreset_pa_en", AW'(pa_if.pa_en), AW'(0));
    chk("midreset_result", AW'(result), AW'(0));
    chk("midreset_busy", AW'(busy), AW'(0));
    chk("midreset_done", AW'(done), AW'(0));
    chk("midreset_error", AW'(error), AW'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk_int("no_done_after_reset", done_cnt, 0);
    $display("reset: asserted after %0d pulses, outputs cleared, no done", pulse_cnt);

    run_op(t_ones, 1'b0, 17, -1, -1, 1'b0, lat);
    chk("post_reset_result_literal", AW'(result), AW'(40));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
